// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter generator with deferred redirect and flush
module pc_gen #(
    parameter int          PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int          PC_STEP  = 4,
    parameter logic [PC_W-1:0] TRAP_VEC = 'h100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic            trap_i,
    output logic [PC_W-1:0] pc_o,
    output logic            flush_o,
    output logic            pend_o,
    output logic            misalign_o
);

    // Low bits below the instruction step; a target with any of them set is misaligned
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'(PC_STEP - 1);
    localparam logic [PC_W-1:0] STEP     = PC_W'(PC_STEP);

    logic [PC_W-1:0] pend_pc;
    logic [PC_W-1:0] redirect_aligned;
    logic            redirect_low;

    // Redirect target with its sub-step bits cleared, and whether any were set
    always_comb begin
        redirect_aligned = redirect_pc_i & ~LOW_MASK;
        redirect_low     = |(redirect_pc_i & LOW_MASK);
    end

    // Next-PC selection: trap > redirect > deferred redirect > stall hold > increment
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o       <= RESET_PC;
            flush_o    <= 1'b0;
            pend_o     <= 1'b0;
            misalign_o <= 1'b0;
            pend_pc    <= '0;
        end else begin
            flush_o    <= 1'b0;
            misalign_o <= 1'b0;
            if (trap_i) begin
                pc_o    <= TRAP_VEC;
                pend_o  <= 1'b0;
                flush_o <= 1'b1;
            end else if (redirect_i && !stall_i) begin
                // A fresh redirect supersedes any target still waiting out a stall
                pc_o       <= redirect_aligned;
                pend_o     <= 1'b0;
                flush_o    <= 1'b1;
                misalign_o <= redirect_low;
            end else if (redirect_i) begin
                // Stalled: remember the target; flush is raised when it is applied
                pend_o     <= 1'b1;
                pend_pc    <= redirect_aligned;
                misalign_o <= redirect_low;
            end else if (pend_o && !stall_i) begin
                pc_o    <= pend_pc;
                pend_o  <= 1'b0;
                flush_o <= 1'b1;
            end else if (!stall_i) begin
                pc_o <= pc_o + STEP;
            end
        end
    end

endmodule
